// File: rtl/decode_stage.sv
// decode_stage: instruction decode pipeline register with load-use stall,
// decode-resolved jump with a single wrong-path bubble, and execute flush.
module decode_stage #(
   parameter int PC_W   = 14,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] opcode_in,
   input  logic [PC_W-1:0]   pc_in,
   input  logic              ex_flush,
   output logic              fetch_en,
   output logic              dec_jump,
   output logic [PC_W-1:0]   dec_target,
   output logic              id_valid,
   output logic [5:0]        id_op,
   output logic [4:0]        id_rd,
   output logic [4:0]        id_rs1,
   output logic [4:0]        id_rs2,
   output logic [DATA_W-1:0] id_imm,
   output logic [PC_W-1:0]   id_pc
);

   localparam logic [5:0] OP_NOP  = 6'h00;
   localparam logic [5:0] OP_LOAD = 6'h23;
   localparam logic [5:0] OP_JMP  = 6'h02;

   typedef enum logic [1:0] {
      st_run    = 2'd0,
      st_stall  = 2'd1,
      st_shadow = 2'd2
   } state_t;

   // sign-extend the 16-bit immediate field to the datapath width
   function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
      return {{(DATA_W-16){imm[15]}}, imm};
   endfunction

   state_t            state_r;
   state_t            state_s;
   logic              bubble_s;
   logic              jump_pend_s;
   logic              hazard_s;
   logic              dec_jump_s;
   logic              fetch_en_s;

   logic              id_valid_r;
   logic [5:0]        id_op_r;
   logic [4:0]        id_rd_r;
   logic [4:0]        id_rs1_r;
   logic [4:0]        id_rs2_r;
   logic [DATA_W-1:0] id_imm_r;
   logic [PC_W-1:0]   id_pc_r;

   // jump and load-use hazard detection from the decode register contents
   always_comb begin
      jump_pend_s = 1'b0;
      hazard_s    = 1'b0;
      dec_jump_s  = 1'b0;
      fetch_en_s  = 1'b1;
      if (id_valid_r && (id_op_r == OP_JMP)) begin
         jump_pend_s = 1'b1;
      end else begin
         jump_pend_s = 1'b0;
      end
      // a jump in decode is never a load, so hazard is naturally suppressed then
      if ((state_r == st_run) && !jump_pend_s && id_valid_r &&
          (id_op_r == OP_LOAD) && (id_rd_r != 5'd0) &&
          ((id_rd_r == opcode_in[20:16]) || (id_rd_r == opcode_in[15:11]))) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
      // a flush redirects fetch, so it overrides both jump and stall
      if (ex_flush) begin
         dec_jump_s = 1'b0;
         fetch_en_s = 1'b1;
      end else begin
         dec_jump_s = jump_pend_s;
         fetch_en_s = !hazard_s;
      end
   end

   // next-state and bubble selection
   always_comb begin
      bubble_s = 1'b0;
      state_s  = st_run;
      if (ex_flush) begin
         bubble_s = 1'b1;
         state_s  = st_run;
      end else begin
         case (state_r)
            st_run: begin
               if (jump_pend_s) begin
                  bubble_s = 1'b1;
                  state_s  = st_shadow;
               end else if (hazard_s) begin
                  bubble_s = 1'b1;
                  state_s  = st_stall;
               end else begin
                  bubble_s = 1'b0;
                  state_s  = st_run;
               end
            end
            st_stall: begin
               bubble_s = 1'b0;
               state_s  = st_run;
            end
            st_shadow: begin
               bubble_s = 1'b0;
               state_s  = st_run;
            end
            default: begin
               bubble_s = 1'b1;
               state_s  = st_run;
            end
         endcase
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= st_run;
      end else begin
         state_r <= state_s;
      end
   end

   // decode pipeline register: capture, or insert a bubble (pc is held)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_valid_r <= 1'b0;
         id_op_r    <= OP_NOP;
         id_rd_r    <= 5'd0;
         id_rs1_r   <= 5'd0;
         id_rs2_r   <= 5'd0;
         id_imm_r   <= {DATA_W{1'b0}};
         id_pc_r    <= {PC_W{1'b1}};
      end else if (bubble_s) begin
         id_valid_r <= 1'b0;
         id_op_r    <= OP_NOP;
         id_rd_r    <= 5'd0;
         id_rs1_r   <= 5'd0;
         id_rs2_r   <= 5'd0;
         id_imm_r   <= {DATA_W{1'b0}};
         id_pc_r    <= id_pc_r;
      end else begin
         id_valid_r <= 1'b1;
         id_op_r    <= opcode_in[31:26];
         id_rd_r    <= opcode_in[25:21];
         id_rs1_r   <= opcode_in[20:16];
         id_rs2_r   <= opcode_in[15:11];
         id_imm_r   <= sext16(opcode_in[15:0]);
         id_pc_r    <= pc_in;
      end
   end

   assign fetch_en   = fetch_en_s;
   assign dec_jump   = dec_jump_s;
   assign dec_target = id_imm_r[PC_W-1:0];
   assign id_valid   = id_valid_r;
   assign id_op      = id_op_r;
   assign id_rd      = id_rd_r;
   assign id_rs1     = id_rs1_r;
   assign id_rs2     = id_rs2_r;
   assign id_imm     = id_imm_r;
   assign id_pc      = id_pc_r;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter PC_W, default 14: program-counter width in 32-bit words.
REQ-002 Parameter DATA_W, default 32: instruction width.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 opcode_in  in  DATA_W  instruction word from the fetch stage.
REQ-006 pc_in  in  PC_W  PC of opcode_in.
REQ-007 ex_flush  in  1  execute-stage redirect; squashes decode contents.
REQ-008 fetch_en  out  1  enable to the fetch stage; 0 holds fetch.
REQ-009 dec_jump, dec_target  out  1, PC_W  decode-resolved jump request and target to fetch.
REQ-010 id_valid  out  1  id_* outputs hold a real instruction.
REQ-011 id_op, id_rd, id_rs1, id_rs2  out  6, 5, 5, 5  decoded fields.
REQ-012 id_imm  out  DATA_W  sign-extended immediate.
REQ-013 id_pc  out  PC_W  PC of the decoded instruction.

Function
REQ-014 Fields: op=[31:26], rd=[25:21], rs1=[20:16], rs2=[15:11], imm=sign-extend [15:0] to DATA_W.
REQ-015 Opcodes: 6'h00 NOP, 6'h23 LOAD, 6'h02 JMP; all others are generic ALU/store, no special handling.
REQ-016 Pipeline register: with fetch_en=1, each posedge captures opcode_in/pc_in into id_*, and id_valid<=1; latency one cycle.
REQ-017 State machine states: RUN, STALL, SHADOW.
REQ-018 RUN: load-use hazard is id_valid=1, id_op=LOAD, id_rd!=0, and id_rd equals opcode_in[20:16] or opcode_in[15:11]; on hazard: fetch_en=0 combinationally, next posedge inserts a bubble (id_valid<=0, id_op<=NOP, fields 0), held instruction not captured, go STALL.
REQ-019 STALL: fetch_en=1; next posedge captures the held instruction normally, go RUN; exactly one bubble per hazard.
REQ-020 JMP captured into id_*: dec_jump=1 and dec_target=id_imm[PC_W-1:0] combinationally for that cycle only; next posedge captures a bubble instead of opcode_in (wrong-path slot), go SHADOW.
REQ-021 SHADOW: one cycle, normal capture, go RUN; dec_jump=0.
REQ-022 ex_flush=1 at a posedge: bubble captured, state goes RUN; has priority over hazard, JMP and STALL; dec_jump forced 0 while ex_flush=1.
REQ-023 Hazard and JMP never coincide (a JMP in id_* is not a LOAD); hazard check is suppressed in the cycle dec_jump=1.
REQ-024 NOP captured with id_valid=1 but never raises hazard or jump.
REQ-025 rd=0 never creates a hazard.
REQ-026 fetch_en=1 in every state except the RUN-hazard cycle.
REQ-027 No combinational path from opcode_in to id_* outputs; dec_jump/dec_target depend on registered state only.

Reset
REQ-028 rst=0 asynchronously: id_valid=0, all id_* fields 0, id_pc=all-ones, state RUN, dec_jump=0, fetch_en=1.
REQ-029 Reset asserted mid-STALL or mid-SHADOW discards the pending instruction; first posedge after release captures opcode_in normally.

Verification
REQ-030 Reset release, opcode_in=32'h0441_0005 pc_in=0 -> next cycle id_valid=1, id_op=6'h01, id_rd=2, id_rs1=1, id_imm=5, id_pc=0.
REQ-031 LOAD rd=3 followed by instr with rs1=3 -> one cycle fetch_en=0, one bubble (id_valid=0), then dependent instr in id_* with its pc; fetch_en back to 1.
REQ-032 JMP imm=16'h0100 at pc 4 -> dec_jump=1, dec_target=14'h0100 one cycle; next cycle id_valid=0; following cycle instruction at pc 14'h0100 captured.
REQ-033 LOAD rd=3 then dependent instr with ex_flush=1 same cycle -> bubble, state RUN, no STALL cycle, fetch_en=1 thereafter.
REQ-034 imm=16'h8000 -> id_imm=32'hFFFF_8000; LOAD rd=0 followed by rs1=0 -> no stall.
REQ-035 rst pulsed low during STALL -> outputs at reset values immediately, no bubble or replay after release.
